// File: rtl/uart_spi_bridge_fifo_if.sv
// Host-side bundle for the UART-to-SPI ingest bridge.
// master: drives tx/r_en and sees FIFO data/flags; slave: the bridge.
interface uart_spi_bridge_fifo_if #(
  parameter int WIDTH = 8
) ();
  logic             tx;
  logic             r_en;
  logic [WIDTH-1:0] read_data;
  logic             full;
  logic             a_full;
  logic             empty;
  logic             a_empty;

  modport master (
    output tx, r_en,
    input  read_data, full, a_full, empty, a_empty
  );

  modport slave (
    input  tx, r_en,
    output read_data, full, a_full, empty, a_empty
  );
endinterface

// File: rtl/uart_spi_bridge_fifo.sv
// UART rx -> holding reg -> internal SPI master/slave -> sync FIFO.
// Ports: clk, reset (async, active low), bus (tx, r_en, read_data, flags).
module uart_spi_bridge_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 1024,
  parameter int LEVEL   = 64,
  parameter int DIVISOR = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_spi_bridge_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WIDTH);
  localparam int DW = $clog2(DIVISOR);
  // Last bit ends one clk early so the mandatory idle clk fits inside
  // one WIDTH*DIVISOR frame period and back-to-back frames keep up.
  localparam int LAST = (DIVISOR > 2) ? DIVISOR - 2 : DIVISOR / 2;

  typedef enum logic [1:0] {U_IDLE, U_DATA, U_STOP} u_state_t;
  typedef enum logic {S_IDLE, S_XFER} s_state_t;

  u_state_t         u_state, u_next;
  logic [BW-1:0]    u_cnt;
  logic [WIDTH-1:0] u_shift;
  logic             u_valid;

  always_comb begin
    u_next  = u_state;
    u_valid = 1'b0;
    unique case (u_state)
      U_IDLE: if (!bus.tx) u_next = U_DATA;
      U_DATA: if (u_cnt == BW'(WIDTH-1)) u_next = U_STOP;
      U_STOP: begin
        u_valid = bus.tx;
        u_next  = U_IDLE;
      end
      default: u_next = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      u_state <= U_IDLE;
      u_cnt   <= '0;
      u_shift <= '0;
    end else begin
      u_state <= u_next;
      if (u_state == U_DATA) begin
        u_shift <= {u_shift[WIDTH-2:0], bus.tx};
        u_cnt   <= u_cnt + 1'b1;
      end else begin
        u_cnt   <= '0;
      end
    end
  end

  s_state_t         s_state, s_next;
  logic [DW-1:0]    s_div;
  logic [BW-1:0]    s_bit;
  logic [WIDTH-1:0] s_shift;
  logic             s_start;
  logic             h_full;
  logic [WIDTH-1:0] h_data;
  logic             h_load;

  assign s_start = (s_state == S_IDLE) && h_full;
  // A word leaving for SPI on this edge frees the slot for a new byte.
  assign h_load  = u_valid && (!h_full || s_start);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_full <= 1'b0;
      h_data <= '0;
    end else begin
      h_full <= h_load || (h_full && !s_start);
      if (h_load) h_data <= u_shift;
    end
  end

  always_comb begin
    s_next = s_state;
    unique case (s_state)
      S_IDLE: if (h_full) s_next = S_XFER;
      S_XFER:
        if (s_bit == BW'(WIDTH-1) && s_div == DW'(LAST))
          s_next = S_IDLE;
      default: s_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_state <= S_IDLE;
      s_div   <= '0;
      s_bit   <= '0;
      s_shift <= '0;
    end else begin
      s_state <= s_next;
      if (s_start) begin
        s_shift <= h_data;
        s_div   <= '0;
        s_bit   <= '0;
      end else if (s_state == S_XFER) begin
        if (s_div == DW'(DIVISOR-1)) begin
          s_div   <= '0;
          s_bit   <= s_bit + 1'b1;
          s_shift <= {s_shift[WIDTH-2:0], 1'b0};
        end else begin
          s_div   <= s_div + 1'b1;
        end
      end
    end
  end

  logic sclk, cs_n, mosi;
  assign cs_n = (s_state != S_XFER);
  assign sclk = !cs_n && (s_div >= DW'(DIVISOR/2));
  assign mosi = s_shift[WIDTH-1];

  logic             sclk_q;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_cnt;
  logic             f_wr;
  logic [WIDTH-1:0] f_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q  <= 1'b0;
      r_shift <= '0;
      r_cnt   <= '0;
      f_wr    <= 1'b0;
      f_wdata <= '0;
    end else begin
      sclk_q <= sclk;
      f_wr   <= 1'b0;
      if (cs_n) begin
        r_cnt <= '0;
      end else if (sclk && !sclk_q) begin
        r_shift <= {r_shift[WIDTH-2:0], mosi};
        if (r_cnt == BW'(WIDTH-1)) begin
          r_cnt   <= '0;
          f_wr    <= 1'b1;
          f_wdata <= {r_shift[WIDTH-2:0], mosi};
        end else begin
          r_cnt   <= r_cnt + 1'b1;
        end
      end
    end
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rd_q;
  logic             do_wr, do_rd;
  logic             is_full, is_empty;

  assign is_full  = (count == CW'(DEPTH));
  assign is_empty = (count == '0);
  assign do_wr    = f_wr && !is_full;
  assign do_rd    = bus.r_en && !is_empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= f_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_q   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_q   <= mem[rd_ptr];
      end
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.read_data = rd_q;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.a_full    = (count >= CW'(DEPTH - LEVEL));
  assign bus.a_empty   = (count <= CW'(LEVEL));
endmodule

// File: tb/tb_uart_spi_bridge_fifo.sv
// Directed bench for uart_spi_bridge_fifo.
// Drives UART frames, drains the FIFO, checks data order and flags.
module tb_uart_spi_bridge_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] bulk [1024];

  always #5 clk = ~clk;

  uart_spi_bridge_fifo_if #(.WIDTH(8)) bif ();

  uart_spi_bridge_fifo #(
    .WIDTH(8), .DEPTH(1024), .LEVEL(64), .DIVISOR(8)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bif)
  );

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) bif.tx = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk) bif.tx = b[i];
    end
    @(negedge clk) bif.tx = stop_bit;
    @(negedge clk) bif.tx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_read();
    bif.r_en = 1'b1;
    @(negedge clk) bif.r_en = 1'b0;
  endtask

  task automatic test_reset();
    bif.tx = 1'b1;
    bif.r_en = 1'b0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bif.read_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: got %h want 00", bif.read_data);
    end
    total++;
    if ({bif.empty, bif.a_empty, bif.full, bif.a_full} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_flags: got e=%b ae=%b f=%b af=%b want 1 1 0 0",
               bif.empty, bif.a_empty, bif.full, bif.a_full);
    end
  endtask

  task automatic test_single();
    int n;
    send_byte(8'hA5, 1'b1);
    n = 0;
    while (bif.empty && n < 68) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bif.empty !== 1'b0) begin
      bad++;
      $display("FAIL single_latency: empty=%b after %0d clks want 0", bif.empty, n);
    end
    pulse_read();
    total++;
    if (bif.read_data !== 8'hA5) begin
      bad++;
      $display("FAIL single_data: got %h want a5", bif.read_data);
    end
    total++;
    if (bif.empty !== 1'b1) begin
      bad++;
      $display("FAIL single_empty: got %b want 1", bif.empty);
    end
  endtask

  task automatic test_framing();
    send_byte(8'h7E, 1'b0);
    idle(80);
    total++;
    if (bif.empty !== 1'b1) begin
      bad++;
      $display("FAIL frame_drop: empty got %b want 1", bif.empty);
    end
    send_byte(8'h11, 1'b1);
    idle(80);
    total++;
    if (bif.empty !== 1'b0) begin
      bad++;
      $display("FAIL frame_next: empty got %b want 0", bif.empty);
    end
    pulse_read();
    total++;
    if (bif.read_data !== 8'h11 || bif.empty !== 1'b1) begin
      bad++;
      $display("FAIL frame_read: got %h e=%b want 11 e=1", bif.read_data, bif.empty);
    end
  endtask

  task automatic test_empty_read();
    pulse_read();
    idle(2);
    total++;
    if (bif.read_data !== 8'h11 || bif.empty !== 1'b1) begin
      bad++;
      $display("FAIL empty_read: got %h e=%b want 11 e=1", bif.read_data, bif.empty);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] stream [3];
    stream[0] = 8'h01;
    stream[1] = 8'h02;
    stream[2] = 8'h03;
    bif.r_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_byte(stream[i], 1'b1);
      idle(70);
      total++;
      if (bif.read_data !== stream[i] || bif.empty !== 1'b1) begin
        bad++;
        $display("FAIL stream_%0d: got %h e=%b want %h e=1",
                 i, bif.read_data, bif.empty, stream[i]);
      end
    end
    bif.r_en = 1'b0;
    send_byte(8'h5A, 1'b1);
    idle(53);
    send_byte(8'hC3, 1'b1);
    idle(53);
    send_byte(8'h96, 1'b1);
    idle(62);
    pulse_read();
    total++;
    if (bif.read_data !== 8'h5A || bif.empty !== 1'b0) begin
      bad++;
      $display("FAIL simul_rw: got %h e=%b want 5a e=0", bif.read_data, bif.empty);
    end
    idle(6);
    pulse_read();
    total++;
    if (bif.read_data !== 8'hC3) begin
      bad++;
      $display("FAIL simul_second: got %h want c3", bif.read_data);
    end
    pulse_read();
    total++;
    if (bif.read_data !== 8'h96 || bif.empty !== 1'b1) begin
      bad++;
      $display("FAIL simul_third: got %h e=%b want 96 e=1", bif.read_data, bif.empty);
    end
  endtask

  task automatic test_bulk_fill();
    logic [3:0] want;
    for (int k = 0; k < 1024; k++) bulk[k] = 8'($urandom);
    for (int k = 0; k < 1024; k++) begin
      send_byte(bulk[k], 1'b1);
      // words 0..k-1 have landed; word k is still in flight
      want = {k == 0, k <= 64, 1'b0, k >= 960};
      total++;
      if ({bif.empty, bif.a_empty, bif.full, bif.a_full} !== want) begin
        bad++;
        $display("FAIL fill_flags_%0d: got e/ae/f/af=%b want %b", k,
                 {bif.empty, bif.a_empty, bif.full, bif.a_full}, want);
      end
      idle(53);
    end
    idle(20);
    total++;
    if ({bif.empty, bif.a_empty, bif.full, bif.a_full} !== 4'b0011) begin
      bad++;
      $display("FAIL fill_full: got e/ae/f/af=%b want 0011",
               {bif.empty, bif.a_empty, bif.full, bif.a_full});
    end
  endtask

  task automatic test_overflow();
    send_byte(8'h3C, 1'b1);
    idle(80);
    total++;
    if ({bif.empty, bif.a_empty, bif.full, bif.a_full} !== 4'b0011) begin
      bad++;
      $display("FAIL overflow_flags: got e/ae/f/af=%b want 0011",
               {bif.empty, bif.a_empty, bif.full, bif.a_full});
    end
  endtask

  task automatic test_drain();
    bif.r_en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      total++;
      if (bif.read_data !== bulk[i]) begin
        bad++;
        $display("FAIL drain_%0d: got %h want %h", i, bif.read_data, bulk[i]);
      end
    end
    bif.r_en = 1'b0;
    idle(3);
    total++;
    if ({bif.empty, bif.a_empty, bif.full, bif.a_full} !== 4'b1100) begin
      bad++;
      $display("FAIL drain_flags: got e/ae/f/af=%b want 1100",
               {bif.empty, bif.a_empty, bif.full, bif.a_full});
    end
    total++;
    if (bif.read_data !== bulk[1023]) begin
      bad++;
      $display("FAIL drain_hold: got %h want %h", bif.read_data, bulk[1023]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_framing();
    test_empty_read();
    test_simultaneous();
    test_bulk_fill();
    test_overflow();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
